uart_tx_arbiter: RTL and testbench

//  Frame-level round-robin arbiter that shares the single UART transmitter among N_REQ byte sources.

---
 rtl/uart_tx_arbiter_if.sv | 62 ++++++
 rtl/uart_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Purpose  : Bundles the requester byte channels and the UART transmitter
//             side of the frame-level transmit arbiter.
//  Ports    : (interface signals)
//             req_valid   [N_REQ]    per-requester byte available
//             req_data    [8*N_REQ]  byte i at [8*i+7:8*i]
//             req_last    [N_REQ]    byte i ends its frame
//             req_ready   [N_REQ]    byte i accepted this cycle
//             tx_data     [8]        to transmitter data_in
//             tx_wr_en    [1]        to transmitter wr_en (one-cycle pulse)
//             tx_busy     [1]        from transmitter Tx_busy
//             grant_id    [clog2]    current/last granted requester
//             active      [1]        a frame is locked
//             err_timeout [1]        tx_busy failed to rise in time
//  Modports : master = arbiter side, slave = requesters + transmitter side
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_wr_en;
    logic               tx_busy;
    logic [GW-1:0]      grant_id;
    logic               active;
    logic               err_timeout;

    modport master (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready,
        output tx_data,
        output tx_wr_en,
        input  tx_busy,
        output grant_id,
        output active,
        output err_timeout
    );

    modport slave (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready,
        input  tx_data,
        input  tx_wr_en,
        output tx_busy,
        input  grant_id,
        input  active,
        input  err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Frame-level round-robin arbiter sharing one UART transmitter
//             among N_REQ byte sources. A granted requester keeps the
//             transmitter until it sends a byte flagged last, so multi-byte
//             messages are never interleaved.
//  Ports    : clk_50m  in   50 MHz system clock
//             clear    in   synchronous active-high reset
//             bus      if   uart_tx_arbiter_if.master (requester channels,
//                           transmitter data/wr_en/busy, status outputs)
//  Params   : N_REQ         number of requesters (2..8)
//             START_TIMEOUT max cycles to wait for tx_busy after wr_en (>=2)
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 8
) (
    input  wire logic           clk_50m,
    input  wire logic           clear,
    uart_tx_arbiter_if.master   bus
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        START = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q,   ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [7:0]      byte_q,  byte_d;
    logic            last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            wr_en_q, wr_en_d;
    logic            err_q,   err_d;

    logic            rr_found;
    logic [GW-1:0]   rr_idx;
    logic [GW-1:0]   rr_cand;
    logic [7:0]      sel_data;
    logic            sel_last;
    logic            sel_valid;
    logic            handshake;
    logic [N_REQ-1:0] ready;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester after the pointer,
    // visiting ptr+1, ptr+2, ... and wrapping N_REQ-1 -> 0.
    // ------------------------------------------------------------------
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_cand = GW'((int'(ptr_q) + k) % N_REQ);
            if (!rr_found && bus.req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Byte/last of the currently granted requester
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data = bus.req_data[8*i +: 8];
                sel_last = bus.req_last[i];
            end
        end
    end

    assign sel_valid = bus.req_valid[grant_q];
    // A byte is only taken while the transmitter is free, so the wr_en
    // pulse that follows can never land on a busy transmitter.
    assign handshake = (state_q == SEND) && sel_valid && !bus.tx_busy;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        err_d   = 1'b0;
        ready   = '0;

        case (state_q)
            IDLE: begin
                // Waiting on tx_busy also covers a transmitter still
                // finishing a byte that was in flight when clear hit.
                if (!bus.tx_busy && rr_found) begin
                    grant_d = rr_idx;
                    state_d = SEND;
                end
            end

            SEND: begin
                ready[grant_q] = sel_valid & ~bus.tx_busy;
                if (handshake) begin
                    byte_d  = sel_data;
                    last_d  = sel_last;
                    wr_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = START;
                end
            end

            START: begin
                if (bus.tx_busy) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(START_TIMEOUT)) begin
                        // Transmitter never acknowledged: abandon frame
                        // and move priority past the offending requester.
                        err_d   = 1'b1;
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (clear) begin
            state_q <= IDLE;
            ptr_q   <= GW'(N_REQ - 1);
            grant_q <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            err_q   <= err_d;
        end
    end

    // tx_data is the captured byte register: valid during the wr_en cycle
    // and left holding the last byte afterwards.
    assign bus.req_ready   = ready;
    assign bus.tx_data     = byte_q;
    assign bus.tx_wr_en    = wr_en_q;
    assign bus.grant_id    = grant_q;
    assign bus.active      = (state_q != IDLE);
    assign bus.err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter with a simple
//             transmitter model (busy for busy_len cycles after wr_en) and
//             per-requester byte queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic clear;
    always #10 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ         (N),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk_50m (clk),
        .clear   (clear),
        .bus     (bus.master)
    );

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;

    // Transmitter model
    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    int   busy_len   = 10;
    int   busy_cnt   = 0;
    assign bus.tx_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_wr_en && busy_len > 0) begin
            model_busy <= 1'b1;
            busy_cnt   <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) model_busy <= 1'b0;
        end
    end

    // Requester queues: {last, data}
    logic [8:0]   rbuf  [N][16];
    logic [3:0]   rhead [N];
    logic [3:0]   rtail [N];
    logic [N-1:0] en;

    // Logs filled by the monitor
    logic [7:0] log_data [64];
    logic [1:0] log_gid  [64];
    int         log_cyc  [64];
    int         nlog;
    int         err_cnt;
    int         err_cyc;
    int         ready_cnt [N];
    int         first_valid_cyc;

    // Requester driver: updates 1 time unit after each rising edge
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (en[i] && rhead[i] != rtail[i]) begin
                    bus.req_valid[i]      = 1'b1;
                    bus.req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
                    bus.req_last[i]       = rbuf[i][rhead[i]][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: samples on the falling edge
    initial begin
        for (int i = 0; i < N; i++) rhead[i] = '0;
        forever begin
            @(negedge clk);
            if (bus.tx_wr_en && nlog < 64) begin
                log_data[nlog] = bus.tx_data;
                log_gid[nlog]  = bus.grant_id;
                log_cyc[nlog]  = cyc;
                nlog++;
            end
            if (bus.err_timeout) begin
                err_cnt++;
                err_cyc = cyc;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    ready_cnt[i]++;
                    rhead[i] = rhead[i] + 4'd1;
                end
            end
            if (bus.req_valid != '0 && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miss);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rbuf[r][rtail[r]] = {l, d};
        rtail[r] = rtail[r] + 4'd1;
    endtask

    task automatic clr_logs();
        nlog = 0;
        err_cnt = 0;
        err_cyc = -1;
        first_valid_cyc = -1;
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (nlog < n && k < budget) begin
            nxt();
            k++;
        end
        vec++;
        if (nlog < n) begin
            miss++;
            $display("FAIL %s: wr_en pulses seen %0d, required %0d", nm, nlog, n);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (bus.active && k < budget) begin
            nxt();
            k++;
        end
        vec++;
        if (bus.active !== 1'b0) begin
            miss++;
            $display("FAIL %s: active=%b, required 0", nm, bus.active);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear = 1'b1;
        nxt();
        nxt();
        vec++; if (bus.tx_wr_en !== 1'b0)    begin miss++; $display("FAIL rst_wr_en: got %b want 0", bus.tx_wr_en); end
        vec++; if (bus.tx_data !== 8'h00)    begin miss++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
        vec++; if (bus.req_ready !== 4'h0)   begin miss++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
        vec++; if (bus.grant_id !== 2'd0)    begin miss++; $display("FAIL rst_grant_id: got %0d want 0", bus.grant_id); end
        vec++; if (bus.active !== 1'b0)      begin miss++; $display("FAIL rst_active: got %b want 0", bus.active); end
        vec++; if (bus.err_timeout !== 1'b0) begin miss++; $display("FAIL rst_err: got %b want 0", bus.err_timeout); end
        clear = 1'b0;
        nxt();
        vec++; if (bus.active !== 1'b0)      begin miss++; $display("FAIL rst_idle_noreq: active got %b want 0", bus.active); end
    endtask

    task automatic test_single();
        clr_logs();
        push(0, 8'h41, 1'b1);
        wait_log(1, 20, "single_wr");
        wait_idle(40, "single_idle");
        vec++; if (nlog !== 1)               begin miss++; $display("FAIL single_pulses: got %0d want 1", nlog); end
        vec++; if (log_data[0] !== 8'h41)    begin miss++; $display("FAIL single_data: got %h want 41", log_data[0]); end
        vec++; if (log_gid[0] !== 2'd0)      begin miss++; $display("FAIL single_gid: got %0d want 0", log_gid[0]); end
        vec++; if (ready_cnt[0] !== 1)       begin miss++; $display("FAIL single_ready: got %0d want 1", ready_cnt[0]); end
        vec++; if (log_cyc[0] - first_valid_cyc !== 2) begin miss++; $display("FAIL single_latency: got %0d want 2", log_cyc[0] - first_valid_cyc); end
        vec++; if (bus.tx_data !== 8'h41)    begin miss++; $display("FAIL single_hold: tx_data got %h want 41", bus.tx_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        clear = 1'b1;
        nxt();
        clear = 1'b0;
        clr_logs();
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1);
        push(2, 8'hC0, 1'b1);
        push(3, 8'hD0, 1'b1);
        wait_log(5, 200, "rr_wr");
        wait_idle(60, "rr_idle");
        for (int k = 0; k < 5; k++) begin
            vec++;
            if (log_gid[k] !== exp_g[k] || log_data[k] !== exp_d[k]) begin
                miss++;
                $display("FAIL rr_order[%0d]: got gid %0d data %h want gid %0d data %h",
                         k, log_gid[k], log_data[k], exp_g[k], exp_d[k]);
            end
        end
        vec++; if (ready_cnt[0] !== 2) begin miss++; $display("FAIL rr_ready0: got %0d want 2", ready_cnt[0]); end
    endtask

    task automatic test_multi_byte();
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h20};
        logic [1:0] exp_g [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        clr_logs();
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h20, 1'b1);
        wait_log(4, 150, "multi_wr");
        wait_idle(60, "multi_idle");
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (log_gid[k] !== exp_g[k] || log_data[k] !== exp_d[k]) begin
                miss++;
                $display("FAIL multi_order[%0d]: got gid %0d data %h want gid %0d data %h",
                         k, log_gid[k], log_data[k], exp_g[k], exp_d[k]);
            end
        end
        // busy high 10 cycles after wr_en, ready one cycle after it falls
        vec++; if (log_cyc[1] - log_cyc[0] !== 13) begin miss++; $display("FAIL multi_b2b_gap: got %0d want 13", log_cyc[1] - log_cyc[0]); end
    endtask

    task automatic test_timeout();
        int k = 0;
        clr_logs();
        busy_len = 0;
        push(3, 8'h33, 1'b1);
        wait_log(1, 30, "tmo_wr");
        while (err_cnt == 0 && k < 30) begin
            nxt();
            k++;
        end
        nxt();
        nxt();
        vec++; if (log_gid[0] !== 2'd3)  begin miss++; $display("FAIL tmo_gid: got %0d want 3", log_gid[0]); end
        vec++; if (err_cnt !== 1)        begin miss++; $display("FAIL tmo_pulse_count: got %0d want 1", err_cnt); end
        vec++; if (err_cyc - log_cyc[0] !== TMO) begin miss++; $display("FAIL tmo_delay: got %0d want %0d", err_cyc - log_cyc[0], TMO); end
        vec++; if (bus.active !== 1'b0)  begin miss++; $display("FAIL tmo_idle: active got %b want 0", bus.active); end
        busy_len = 10;
        push(0, 8'h44, 1'b1);
        push(3, 8'h34, 1'b1);
        wait_log(3, 100, "tmo_next_wr");
        wait_idle(60, "tmo_next_idle");
        vec++; if (log_gid[1] !== 2'd0 || log_data[1] !== 8'h44) begin miss++; $display("FAIL tmo_next_grant: got gid %0d data %h want gid 0 data 44", log_gid[1], log_data[1]); end
        vec++; if (log_gid[2] !== 2'd3 || log_data[2] !== 8'h34) begin miss++; $display("FAIL tmo_then: got gid %0d data %h want gid 3 data 34", log_gid[2], log_data[2]); end
    endtask

    task automatic test_clear_drain();
        int saw_active = 0;
        clr_logs();
        push(2, 8'h62, 1'b1);
        wait_log(1, 20, "clr_wr");
        nxt();
        nxt();
        vec++; if (bus.active !== 1'b1) begin miss++; $display("FAIL clr_in_drain: active got %b want 1", bus.active); end
        push(1, 8'h71, 1'b1);
        hold_busy = 1'b1;
        clear = 1'b1;
        nxt();
        clear = 1'b0;
        vec++; if (bus.active !== 1'b0)    begin miss++; $display("FAIL clr_active: got %b want 0", bus.active); end
        vec++; if (bus.grant_id !== 2'd0)  begin miss++; $display("FAIL clr_grant: got %0d want 0", bus.grant_id); end
        vec++; if (bus.tx_data !== 8'h00)  begin miss++; $display("FAIL clr_tx_data: got %h want 00", bus.tx_data); end
        vec++; if (bus.tx_wr_en !== 1'b0)  begin miss++; $display("FAIL clr_wr_en: got %b want 0", bus.tx_wr_en); end
        for (int i = 0; i < 15; i++) begin
            nxt();
            if (bus.active) saw_active++;
        end
        vec++; if (saw_active !== 0) begin miss++; $display("FAIL clr_wait_busy: active cycles got %0d want 0", saw_active); end
        vec++; if (nlog !== 1)       begin miss++; $display("FAIL clr_no_wr: wr_en pulses got %0d want 1", nlog); end
        hold_busy = 1'b0;
        wait_log(2, 60, "clr_resume_wr");
        wait_idle(60, "clr_resume_idle");
        vec++; if (log_gid[1] !== 2'd1 || log_data[1] !== 8'h71) begin miss++; $display("FAIL clr_resume: got gid %0d data %h want gid 1 data 71", log_gid[1], log_data[1]); end
    endtask

    task automatic test_stall();
        clr_logs();
        push(2, 8'h80, 1'b0);
        push(2, 8'h81, 1'b1);
        push(3, 8'h90, 1'b1);
        wait_log(1, 20, "stall_wr");
        en[2] = 1'b0;
        for (int i = 0; i < 25; i++) nxt();
        vec++; if (log_gid[0] !== 2'd2 || log_data[0] !== 8'h80) begin miss++; $display("FAIL stall_first: got gid %0d data %h want gid 2 data 80", log_gid[0], log_data[0]); end
        vec++; if (nlog !== 1)           begin miss++; $display("FAIL stall_no_wr: wr_en pulses got %0d want 1", nlog); end
        vec++; if (ready_cnt[3] !== 0)   begin miss++; $display("FAIL stall_other: ready3 got %0d want 0", ready_cnt[3]); end
        vec++; if (bus.grant_id !== 2'd2) begin miss++; $display("FAIL stall_grant: got %0d want 2", bus.grant_id); end
        vec++; if (bus.active !== 1'b1)  begin miss++; $display("FAIL stall_lock: active got %b want 1", bus.active); end
        en[2] = 1'b1;
        wait_log(3, 80, "stall_resume_wr");
        wait_idle(60, "stall_resume_idle");
        vec++; if (log_gid[1] !== 2'd2 || log_data[1] !== 8'h81) begin miss++; $display("FAIL stall_resume: got gid %0d data %h want gid 2 data 81", log_gid[1], log_data[1]); end
        vec++; if (log_gid[2] !== 2'd3 || log_data[2] !== 8'h90) begin miss++; $display("FAIL stall_next: got gid %0d data %h want gid 3 data 90", log_gid[2], log_data[2]); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        clear = 1'b1;
        en    = '1;
        for (int i = 0; i < N; i++) rtail[i] = '0;
        clr_logs();
        test_reset();
        test_single();
        test_round_robin();
        test_multi_byte();
        test_timeout();
        test_clear_drain();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire
